// File: rtl/cmd_engine.sv
// Command engine: a synchronized strobe loads a FIFO, and an FSM decodes each command into per-channel trigger settings.
// Frequency commands share one restoring divider, which derives both the pulse width and the trigger period.

module cmd_engine_chan #(
   parameter logic [19:0] CYC_RST = 20'd1000000
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        cfg_we,
   input  logic        div_we,
   input  logic [2:0]  op,
   input  logic [18:0] param,
   input  logic        pulse_keep,
   input  logic [11:0] pulse_val,
   input  logic [19:0] cycle_val,
   output logic        run,
   output logic        outmode,
   output logic        outnegedge,
   output logic [15:0] raw_size,
   output logic [2:0]  rate,
   output logic [19:0] cycle,
   output logic [11:0] pulse
);
   // Opcode 7 reuses the reset path so both always restore the same values.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n || (cfg_we && op == 3'd7)) begin
         run        <= 1'b0;
         outmode    <= 1'b0;
         outnegedge <= 1'b0;
         raw_size   <= 16'd128;
         rate       <= 3'd1;
         cycle      <= CYC_RST;
         pulse      <= 12'd100;
      end else if (cfg_we) begin
         case (op)
            3'd1:    run        <= 1'b1;
            3'd2:    run        <= 1'b0;
            3'd3:    outmode    <= param[0];
            3'd4:    outnegedge <= param[0];
            3'd6:    {rate, raw_size} <= param;
            default: ;
         endcase
      end else if (div_we) begin
         cycle <= cycle_val;
         if (!pulse_keep) pulse <= pulse_val;
      end
   end
endmodule

module cmd_engine #(
   parameter int CHANNELS   = 2,
   parameter int FIFO_DEPTH = 4,
   parameter int CLK_HZ     = 100000000
) (
   input  logic                     i_clk,
   input  logic                     i_rst_n,
   input  logic                     i_cmd_come,
   input  logic [15:0]              i_cmd,
   input  logic [31:0]              i_cmd_param,
   output logic [CHANNELS-1:0]      o_run,
   output logic [CHANNELS-1:0]      o_outmode,
   output logic [CHANNELS-1:0]      o_outnegedge,
   output logic [16*CHANNELS-1:0]   o_waveRawSize,
   output logic [3*CHANNELS-1:0]    o_waveRate,
   output logic [20*CHANNELS-1:0]   o_cycle,
   output logic [12*CHANNELS-1:0]   o_pulse,
   output logic                     o_finish,
   output logic [15:0]              o_finish_code,
   output logic                     o_busy,
   output logic                     o_overflow
);
   localparam int          AW    = $clog2(FIFO_DEPTH);
   localparam logic [AW:0] FULL  = (AW+1)'(FIFO_DEPTH);
   localparam logic [4:0]  NCH   = 5'(CHANNELS);
   localparam logic [26:0] HZ27  = 27'(CLK_HZ);

   typedef enum logic [2:0] {IDLE, FETCH, EXEC, DIV_P, DIV_C, DONE} state_t;
   state_t state;

   logic          sync1, sync2, cmd_edge, push, pop;
   logic [47:0]   fifo_mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [AW:0]   count;

   assign cmd_edge = sync1 && !sync2;
   assign pop      = (state == FETCH);
   assign push     = cmd_edge && (count != FULL || pop);
   assign o_busy   = (count != '0) || (state != IDLE);

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         sync1      <= 1'b0;
         sync2      <= 1'b0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         o_overflow <= 1'b0;
      end else begin
         sync1      <= i_cmd_come;
         sync2      <= sync1;
         o_overflow <= cmd_edge && !push;
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: ;
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (push) fifo_mem[wr_ptr] <= {i_cmd, i_cmd_param};
   end

   logic [15:0] cmd_r;
   logic [31:0] param_r;
   logic [4:0]  cnt;
   logic [15:0] rem;
   logic [25:0] quo;
   logic [26:0] dvd;
   logic [11:0] pulse_new;

   logic [3:0]  ch;
   logic [11:0] op;
   logic        op_known, bc_ok, ch_ok;
   logic [15:0] exec_code;

   assign ch       = cmd_r[15:12];
   assign op       = cmd_r[11:0];
   assign op_known = (op >= 12'd1) && (op <= 12'd7);
   assign bc_ok    = (ch == 4'hF) && (op == 12'd1 || op == 12'd2 || op == 12'd7);
   assign ch_ok    = {1'b0, ch} < NCH;

   always_comb begin
      exec_code = 16'h0000;
      if (!op_known)                                  exec_code = 16'h0001;
      else if (!(bc_ok || ch_ok))                     exec_code = 16'h0002;
      else if (op == 12'd5 && param_r[15:0] == '0)   exec_code = 16'h0003;
   end

   // One restoring step per cycle; the divisor is fixed at 10 for the pulse pass.
   logic [15:0] div_sor, rem_nxt;
   logic [16:0] trial;
   logic        ge;
   logic [26:0] quo_nxt;
   logic [11:0] pulse_sat;
   logic [19:0] cycle_sat;

   assign div_sor   = (state == DIV_P) ? 16'd10 : param_r[15:0];
   assign trial     = {rem, dvd[26]};
   assign ge        = trial >= {1'b0, div_sor};
   assign rem_nxt   = ge ? 16'(trial - {1'b0, div_sor}) : trial[15:0];
   assign quo_nxt   = {quo, ge};
   assign pulse_sat = (quo_nxt[15:12] != '0) ? 12'hFFF : quo_nxt[11:0];
   assign cycle_sat = (quo_nxt[26:20] != '0) ? 20'hFFFFF : quo_nxt[19:0];

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state         <= IDLE;
         cmd_r         <= '0;
         param_r       <= '0;
         cnt           <= '0;
         rem           <= '0;
         quo           <= '0;
         dvd           <= '0;
         pulse_new     <= '0;
         o_finish      <= 1'b0;
         o_finish_code <= '0;
      end else begin
         o_finish <= 1'b0;
         case (state)
            IDLE:  if (count != '0) state <= FETCH;
            FETCH: begin
               {cmd_r, param_r} <= fifo_mem[rd_ptr];
               state            <= EXEC;
            end
            EXEC: begin
               if (op == 12'd5 && exec_code == 16'h0000) begin
                  rem   <= '0;
                  quo   <= '0;
                  dvd   <= {param_r[31:16], 11'd0};
                  cnt   <= 5'd15;
                  state <= DIV_P;
               end else begin
                  o_finish      <= 1'b1;
                  o_finish_code <= exec_code;
                  state         <= DONE;
               end
            end
            DIV_P: begin
               rem <= rem_nxt;
               quo <= quo_nxt[25:0];
               dvd <= {dvd[25:0], 1'b0};
               cnt <= cnt - 5'd1;
               if (cnt == '0) begin
                  pulse_new <= pulse_sat;
                  rem       <= '0;
                  quo       <= '0;
                  dvd       <= HZ27;
                  cnt       <= 5'd26;
                  state     <= DIV_C;
               end
            end
            DIV_C: begin
               rem <= rem_nxt;
               quo <= quo_nxt[25:0];
               dvd <= {dvd[25:0], 1'b0};
               cnt <= cnt - 5'd1;
               if (cnt == '0) begin
                  o_finish      <= 1'b1;
                  o_finish_code <= 16'h0000;
                  state         <= DONE;
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   logic cfg_go, div_go, pulse_keep;
   assign cfg_go     = (state == EXEC) && (exec_code == 16'h0000) && (op != 12'd5);
   assign div_go     = (state == DIV_C) && (cnt == '0);
   assign pulse_keep = (param_r[31:16] == '0);

   for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
      cmd_engine_chan #(.CYC_RST(20'(CLK_HZ / 100))) u_ch (
         .i_clk      (i_clk),
         .i_rst_n    (i_rst_n),
         .cfg_we     (cfg_go && (bc_ok || ch == 4'(k))),
         .div_we     (div_go && ch == 4'(k)),
         .op         (cmd_r[2:0]),
         .param      (param_r[18:0]),
         .pulse_keep (pulse_keep),
         .pulse_val  (pulse_new),
         .cycle_val  (cycle_sat),
         .run        (o_run[k]),
         .outmode    (o_outmode[k]),
         .outnegedge (o_outnegedge[k]),
         .raw_size   (o_waveRawSize[16*k +: 16]),
         .rate       (o_waveRate[3*k +: 3]),
         .cycle      (o_cycle[20*k +: 20]),
         .pulse      (o_pulse[12*k +: 12])
      );
   end
endmodule

// File: tb/tb_cmd_engine.sv
// Scoreboard bench for cmd_engine: expected finish codes and latencies are queued at each strobe and matched on o_finish.
module tb_cmd_engine;
   localparam int CH = 2;

   logic            i_clk, i_rst_n, i_cmd_come;
   logic [15:0]     i_cmd;
   logic [31:0]     i_cmd_param;
   logic [CH-1:0]   o_run, o_outmode, o_outnegedge;
   logic [16*CH-1:0] o_waveRawSize;
   logic [3*CH-1:0] o_waveRate;
   logic [20*CH-1:0] o_cycle;
   logic [12*CH-1:0] o_pulse;
   logic            o_finish, o_busy, o_overflow;
   logic [15:0]     o_finish_code;

   cmd_engine #(.CHANNELS(CH), .FIFO_DEPTH(4), .CLK_HZ(100000000)) dut (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .i_cmd_come(i_cmd_come), .i_cmd(i_cmd),
      .i_cmd_param(i_cmd_param), .o_run(o_run), .o_outmode(o_outmode),
      .o_outnegedge(o_outnegedge), .o_waveRawSize(o_waveRawSize), .o_waveRate(o_waveRate),
      .o_cycle(o_cycle), .o_pulse(o_pulse), .o_finish(o_finish), .o_finish_code(o_finish_code),
      .o_busy(o_busy), .o_overflow(o_overflow)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   int checks = 0, failures = 0;
   int cyc = 0, ovf_cnt = 0, busy_drop = 0;
   bit busy_watch = 0;

   typedef struct { logic [15:0] code; int fin; string tag; } exp_t;
   exp_t exp_q[$];
   exp_t me;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   always @(posedge i_clk) cyc <= cyc + 1;

   always @(negedge i_clk) begin
      if (o_overflow) ovf_cnt++;
      if (busy_watch && exp_q.size() != 0 && !o_busy) busy_drop++;
      if (i_rst_n && o_finish) begin
         if (exp_q.size() == 0) chk("unexp_finish", o_finish, 1'b0);
         else begin
            me = exp_q.pop_front();
            chk({me.tag, "_code"}, o_finish_code, me.code);
            if (me.fin >= 0) chk({me.tag, "_lat"}, cyc, me.fin);
         end
      end
   end

   // lat < 0 skips the latency check (command may queue behind others).
   task automatic send(input string tag, input logic [15:0] cmd, input logic [31:0] prm,
                       input logic [15:0] code, input int lat, input bit push);
      exp_t e;
      @(negedge i_clk);
      i_cmd = cmd; i_cmd_param = prm; i_cmd_come = 1'b1;
      if (push) begin
         e.code = code; e.fin = (lat < 0) ? -1 : cyc + lat; e.tag = tag;
         exp_q.push_back(e);
      end
      repeat (2) @(negedge i_clk);
      i_cmd_come = 1'b0;
      @(negedge i_clk);
   endtask

   task automatic drain(input string tag);
      for (int i = 0; i < 400 && (exp_q.size() != 0 || o_busy); i++) @(negedge i_clk);
      chk({tag, "_drain"}, exp_q.size(), 0);
      chk({tag, "_idle"}, o_busy, 1'b0);
   endtask

   task automatic chk_defaults(input string tag);
      chk({tag, "_run"}, o_run, '0);
      chk({tag, "_mode"}, o_outmode, '0);
      chk({tag, "_neg"}, o_outnegedge, '0);
      chk({tag, "_fin"}, o_finish, 1'b0);
      chk({tag, "_code"}, o_finish_code, 16'h0);
      chk({tag, "_busy"}, o_busy, 1'b0);
      chk({tag, "_ovf"}, o_overflow, 1'b0);
      for (int k = 0; k < CH; k++) begin
         chk({tag, "_raw"}, o_waveRawSize[16*k +: 16], 16'd128);
         chk({tag, "_rate"}, o_waveRate[3*k +: 3], 3'd1);
         chk({tag, "_cyc"}, o_cycle[20*k +: 20], 20'd1000000);
         chk({tag, "_pls"}, o_pulse[12*k +: 12], 12'd100);
      end
   endtask

   initial begin
      int ovf0;
      i_rst_n = 1'b0; i_cmd_come = 1'b0; i_cmd = '0; i_cmd_param = '0;
      repeat (3) @(negedge i_clk);
      chk_defaults("rst");
      i_rst_n = 1'b1;

      send("run1", 16'h1001, 32'h0, 16'h0, 5, 1);
      drain("run1");
      chk("run1_run", o_run, 2'b10);

      send("f1a", 16'h1005, 32'h0FA0_00C8, 16'h0, 48, 1);
      drain("f1a");
      chk("f1a_pls", o_pulse[12 +: 12], 12'd400);
      chk("f1a_cyc", o_cycle[20 +: 20], 20'd500000);
      send("f1sat", 16'h1005, 32'hFFFF_0003, 16'h0, 48, 1);
      drain("f1sat");
      chk("f1sat_pls", o_pulse[12 +: 12], 12'hFFF);
      chk("f1sat_cyc", o_cycle[20 +: 20], 20'hFFFFF);

      send("f0b", 16'h0005, 32'hA000_2710, 16'h0, 48, 1);
      drain("f0b");
      chk("f0b_pls", o_pulse[0 +: 12], 12'hFFF);
      send("f0c", 16'h0005, 32'h9FF6_2710, 16'h0, 48, 1);
      drain("f0c");
      chk("f0c_pls", o_pulse[0 +: 12], 12'd4095);
      chk("f0c_cyc", o_cycle[0 +: 20], 20'd10000);
      send("f0d", 16'h0005, 32'h0000_0001, 16'h0, 48, 1);
      drain("f0d");
      chk("f0d_pls", o_pulse[0 +: 12], 12'd4095);
      chk("f0d_cyc", o_cycle[0 +: 20], 20'hFFFFF);
      send("f0z", 16'h0005, 32'h0, 16'h3, 5, 1);
      drain("f0z");
      chk("f0z_cyc", o_cycle[0 +: 20], 20'hFFFFF);
      send("f0e", 16'h0005, 32'h03E8_2710, 16'h0, 48, 1);
      drain("f0e");
      chk("f0e_pls", o_pulse[0 +: 12], 12'd100);
      chk("f0e_cyc", o_cycle[0 +: 20], 20'd10000);

      send("mode", 16'h0003, 32'h1, 16'h0, 5, 1);
      send("neg", 16'h0004, 32'h1, 16'h0, -1, 1);
      send("wave", 16'h0006, 32'h0005_0200, 16'h0, -1, 1);
      drain("cfg");
      chk("cfg_mode", o_outmode, 2'b01);
      chk("cfg_neg", o_outnegedge, 2'b01);
      chk("cfg_rate", o_waveRate[0 +: 3], 3'd5);
      chk("cfg_raw", o_waveRawSize[0 +: 16], 16'd512);

      send("badch", 16'h5001, 32'h0, 16'h2, 5, 1);
      send("badop", 16'h1009, 32'h0, 16'h1, -1, 1);
      send("bcbad", 16'hF003, 32'h1, 16'h2, -1, 1);
      send("op0", 16'h0000, 32'h0, 16'h1, -1, 1);
      drain("err");
      chk("err_run", o_run, 2'b10);
      chk("err_mode", o_outmode, 2'b01);
      send("bcrun", 16'hF001, 32'h0, 16'h0, 5, 1);
      drain("bcrun");
      chk("bcrun_run", o_run, 2'b11);
      send("bcstop", 16'hF002, 32'h0, 16'h0, 5, 1);
      drain("bcstop");
      chk("bcstop_run", o_run, 2'b00);

      send("rst0", 16'h0007, 32'h0, 16'h0, 5, 1);
      drain("rst0");
      chk("rst0_mode", o_outmode, 2'b00);
      chk("rst0_neg", o_outnegedge, 2'b00);
      chk("rst0_raw", o_waveRawSize[0 +: 16], 16'd128);
      chk("rst0_cyc", o_cycle[0 +: 20], 20'd1000000);
      chk("rst0_pls1", o_pulse[12 +: 12], 12'hFFF);

      ovf0 = ovf_cnt;
      send("b0", 16'h0005, 32'h0FA0_00C8, 16'h0, 48, 1);
      busy_watch = 1;
      send("b1", 16'h1001, 32'h0, 16'h0, -1, 1);
      send("b2", 16'h5001, 32'h0, 16'h2, -1, 1);
      send("b3", 16'h0009, 32'h0, 16'h1, -1, 1);
      send("b4", 16'h0005, 32'h0, 16'h3, -1, 1);
      send("b5", 16'h1002, 32'h0, 16'h0, -1, 0);
      drain("burst");
      busy_watch = 0;
      chk("burst_ovf", ovf_cnt - ovf0, 1);
      chk("burst_busy", busy_drop, 0);
      chk("burst_run", o_run, 2'b10);
      chk("burst_pls", o_pulse[0 +: 12], 12'd400);
      chk("burst_cyc", o_cycle[0 +: 20], 20'd500000);

      send("pre", 16'h0006, 32'h0003_0040, 16'h0, 5, 1);
      send("pre1", 16'h0008, 32'h0, 16'h1, -1, 1);
      drain("pre");
      chk("pre_rate", o_waveRate[0 +: 3], 3'd3);
      chk("pre_raw", o_waveRawSize[0 +: 16], 16'd64);
      send("abort", 16'h0005, 32'h03E8_2710, 16'h0, -1, 0);
      repeat (28) @(negedge i_clk);
      i_rst_n = 1'b0;
      @(negedge i_clk);
      chk_defaults("abort");
      i_rst_n = 1'b1;
      repeat (60) @(negedge i_clk);
      chk_defaults("post");
      chk("post_q", exp_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/cmd_engine.md
CMD_ENGINE -- requirements
Module: cmd_engine

Interface
REQ-001 Parameter CHANNELS, default 2, number of independent trigger/acquisition channels (1..8).
REQ-002 Parameter FIFO_DEPTH, default 4, command queue depth (power of 2, >=2).
REQ-003 Parameter CLK_HZ, default 100000000, clock frequency, cycle-divider dividend (< 2^27).
REQ-004 i_clk  in  1  system clock; all logic on rising edge.
REQ-005 i_rst_n  in  1  reset, synchronous, active-low.
REQ-006 i_cmd_come  in  1  asynchronous command strobe; rising edge marks a new command.
REQ-007 i_cmd  in  16  [15:12] channel index (4'hF = broadcast), [11:0] opcode.
REQ-008 i_cmd_param  in  32  command parameter.
REQ-009 o_run, o_outmode, o_outnegedge  out  CHANNELS each  per-channel run enable, trigger mode, trigger edge.
REQ-010 o_waveRawSize  out  16*CHANNELS  per-channel raw wave size, channel k at [16k+15:16k].
REQ-011 o_waveRate  out  3*CHANNELS  per-channel wave rate.
REQ-012 o_cycle  out  20*CHANNELS  per-channel trigger period, 10 ns units.
REQ-013 o_pulse  out  12*CHANNELS  per-channel pulse width, 10 ns units.
REQ-014 o_finish  out  1  one-cycle pulse per completed command.
REQ-015 o_finish_code  out  16  result of last completed command; held until next o_finish.
REQ-016 o_busy  out  1  high while FIFO non-empty or FSM not IDLE.
REQ-017 o_overflow  out  1  one-cycle pulse when a command is dropped on full FIFO.

Function
REQ-018 i_cmd_come through 2-FF synchronizer; edge = sync stage 2 low, stage 1 high; one FIFO write, cycle after edge, of {i_cmd, i_cmd_param} sampled that cycle.
REQ-019 FIFO full at write: command dropped, o_overflow pulses; same-cycle read frees a slot, write accepted.
REQ-020 FSM states IDLE, FETCH, EXEC, DIV_P, DIV_C, DONE; undefined encodings -> IDLE.
REQ-021 IDLE -> FETCH when FIFO non-empty; FETCH pops head into cmd/param registers; FETCH -> EXEC.
REQ-022 EXEC decodes; opcode 5 with valid channel and nonzero param[15:0] -> DIV_P, all other cases -> DONE.
REQ-023 Opcodes: 1 run<=1; 2 run<=0; 3 outmode<=param[0]; 4 outnegedge<=param[0]; 6 {waveRate,waveRawSize}<=param[18:0]; 7 restore channel reset defaults; 5 set frequency.
REQ-024 Broadcast 4'hF legal only for opcodes 1, 2, 7 (all channels); otherwise channel index >= CHANNELS -> no update, code 16'h0002.
REQ-025 Unknown opcode (0, >7) -> no update, code 16'h0001; opcode 5 with param[15:0]==0 -> no update, code 16'h0003; success -> 16'h0000.
REQ-026 Opcode 5: shared iterative restoring divider, 1 quotient bit/cycle; DIV_P exactly 16 cycles, param[31:16]/10; DIV_C exactly 27 cycles, CLK_HZ/param[15:0].
REQ-027 Pulse quotient > 4095 -> 12'hFFF; cycle quotient > 2^20-1 -> 20'hFFFFF; both truncating division.
REQ-028 param[31:16]==0 -> o_pulse unchanged, DIV_P still 16 cycles; o_pulse and o_cycle updated together on DIV_C -> DONE.
REQ-029 DONE: o_finish high one cycle, o_finish_code updated same cycle; DONE -> IDLE.
REQ-030 Latency: non-divide command, o_finish 3 cycles after FIFO write (IDLE, FETCH, EXEC, DONE); opcode 5 adds 43 cycles.
REQ-031 Strobes arriving during execution are queued; commands execute strictly in arrival order.

Reset
REQ-032 i_rst_n low at clock edge: FIFO empty, FSM IDLE, synchronizer 0, o_finish/o_overflow 0, o_busy 0, o_finish_code 0.
REQ-033 Per-channel reset values: run 0, outmode 0, outnegedge 0, waveRawSize 128, waveRate 1, cycle CLK_HZ/100 (1000000), pulse 100.
REQ-034 Reset mid-division aborts; no partial quotient reaches outputs.

Verification
REQ-035 Cmd 16'h1001 (ch1 start) -> o_run[1]=1, others unchanged, o_finish 3 cycles after write, code 0.
REQ-036 Cmd 16'h0005, param 32'h03E8_2710 -> o_pulse[0]=100, o_cycle[0]=10000, o_finish 46 cycles after write.
REQ-037 Cmd 16'h0005, param 32'h0000_0001 -> o_cycle[0]=20'hFFFFF, o_pulse[0] unchanged; param 0 -> code 3, no change.
REQ-038 FIFO_DEPTH+2 strobes during one divide -> FIFO_DEPTH+1 executed in order, 1 o_overflow pulse, o_busy high throughout.
REQ-039 Cmd 16'h5001 with CHANNELS=2 -> code 2; 16'hF002 -> all o_run 0; opcode 9 -> code 1.
REQ-040 Reset asserted 10 cycles into DIV_C -> all outputs at reset values, no o_finish afterwards.
